// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the decode-stage instruction fields, pipeline events and the
// stage-control / status outputs of the hazard controller.
//   master : the pipeline side (drives decode fields and events, reads
//            the stage controls and status)
//   slave  : the hazard controller itself
// Signals:
//   id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_regwrt, id_rd,
//   id_halt        decode-stage instruction description
//   ex_br_taken    branch/jump resolved taken in EX
//   mem_busy       data memory not ready, pipeline freezes
//   pc_we, ifid_we, idex_we        stage write enables
//   ifid_flush, idex_bubble        NOP insertion into IF/ID, ID/EX
//   halted, state, stall_cycles    status
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    logic        id_valid;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_regwrt;
    logic [2:0]  id_rd;
    logic        id_halt;
    logic        ex_br_taken;
    logic        mem_busy;
    logic        pc_we;
    logic        ifid_we;
    logic        idex_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_regwrt, id_rd, id_halt, ex_br_taken, mem_busy,
        input  pc_we, ifid_we, idex_we, ifid_flush, idex_bubble,
               halted, state, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_regwrt, id_rd, id_halt, ex_br_taken, mem_busy,
        output pc_we, ifid_we, idex_we, ifid_flush, idex_bubble,
               halted, state, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard / stall / flush controller for a 5-stage in-order pipeline.
// Tracks destination registers of the instructions in EX and MEM, stalls
// decode on read-after-write, flushes on taken branches, freezes on a busy
// data memory and drains the pipeline after HALT.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pipe_hazard_ctrl_if.slave (decode fields, events, controls, status)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic                     clk,
    input  logic                     rst,
    pipe_hazard_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_UNUSED = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        ex_v_q, ex_v_d;
    logic [2:0]  ex_rd_q, ex_rd_d;
    logic        mem_v_q, mem_v_d;
    logic [2:0]  mem_rd_q, mem_rd_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_q, stall_d;

    logic        raw_s;
    logic        stall_inc_s;
    logic        pc_we_s, ifid_we_s, idex_we_s, ifid_flush_s, idex_bubble_s;

    // Read-after-write detection against EX and MEM entries (r0 included).
    always_comb begin
        raw_s = bus.id_valid &
                ((bus.id_rs_used & ((ex_v_q  & (ex_rd_q  == bus.id_rs)) |
                                    (mem_v_q & (mem_rd_q == bus.id_rs)))) |
                 (bus.id_rt_used & ((ex_v_q  & (ex_rd_q  == bus.id_rt)) |
                                    (mem_v_q & (mem_rd_q == bus.id_rt)))));
    end

    // Next-state and stage-control decode; every path starts from "hold".
    always_comb begin
        state_d       = state_q;
        ex_v_d        = ex_v_q;
        ex_rd_d       = ex_rd_q;
        mem_v_d       = mem_v_q;
        mem_rd_d      = mem_rd_q;
        drain_cnt_d   = drain_cnt_q;
        stall_inc_s   = 1'b0;
        pc_we_s       = 1'b0;
        ifid_we_s     = 1'b0;
        idex_we_s     = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;

        if (rst) begin
            // Register reset happens in the flop block; here only the
            // outputs are forced so the stages load NOPs during reset.
            pc_we_s       = 1'b1;
            ifid_we_s     = 1'b1;
            idex_we_s     = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (bus.mem_busy) begin
            // Freeze: everything holds; only RUN accounts the lost cycle.
            stall_inc_s = (state_q == ST_RUN) || (state_q == ST_UNUSED);
        end else begin
            case (state_q)
                ST_DRAIN: begin
                    pc_we_s       = 1'b0;
                    ifid_we_s     = 1'b1;
                    idex_we_s     = 1'b1;
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    ex_v_d        = 1'b0;
                    ex_rd_d       = 3'd0;
                    mem_v_d       = ex_v_q;
                    mem_rd_d      = ex_rd_q;
                    drain_cnt_d   = drain_cnt_q + 2'd1;
                    if (drain_cnt_q == 2'd2) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    // RUN, and the unused encoding which behaves as RUN.
                    state_d  = ST_RUN;
                    mem_v_d  = ex_v_q;
                    mem_rd_d = ex_rd_q;
                    if (bus.ex_br_taken) begin
                        // Any HALT in ID is squashed with the wrong path.
                        pc_we_s       = 1'b1;
                        ifid_we_s     = 1'b1;
                        idex_we_s     = 1'b1;
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                        ex_v_d        = 1'b0;
                        ex_rd_d       = 3'd0;
                    end else if (raw_s) begin
                        pc_we_s       = 1'b0;
                        ifid_we_s     = 1'b0;
                        idex_we_s     = 1'b1;
                        idex_bubble_s = 1'b1;
                        ex_v_d        = 1'b0;
                        ex_rd_d       = 3'd0;
                        stall_inc_s   = 1'b1;
                    end else begin
                        pc_we_s   = 1'b1;
                        ifid_we_s = 1'b1;
                        idex_we_s = 1'b1;
                        ex_v_d    = bus.id_valid & bus.id_regwrt;
                        ex_rd_d   = bus.id_rd;
                        if (bus.id_valid && bus.id_halt) begin
                            // HALT enters EX; stop fetching behind it.
                            pc_we_s      = 1'b0;
                            ifid_flush_s = 1'b1;
                            drain_cnt_d  = 2'd0;
                            state_d      = ST_DRAIN;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
            endcase
        end

        if (stall_inc_s && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State, scoreboard and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ex_v_q      <= 1'b0;
            ex_rd_q     <= 3'd0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= 3'd0;
            drain_cnt_q <= 2'd0;
            stall_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            drain_cnt_q <= drain_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.pc_we        = pc_we_s;
    assign bus.ifid_we      = ifid_we_s;
    assign bus.idex_we      = idex_we_s;
    assign bus.ifid_flush   = ifid_flush_s;
    assign bus.idex_bubble  = idex_bubble_s;
    assign bus.halted       = (state_q == ST_HALTED);
    assign bus.state        = state_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Table-driven bench: each record holds one cycle of inputs and the outputs
// expected in that cycle. Expected records are queued when the inputs are
// driven and popped when the outputs are sampled on the falling edge.
// Enable vector order: {pc_we, ifid_we, idex_we, ifid_flush, idex_bubble}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [2:0]  rs;
        logic        rsu;
        logic [2:0]  rt;
        logic        rtu;
        logic        regw;
        logic [2:0]  rd;
        logic        halt;
        logic        br;
        logic        busy;
        logic [4:0]  en;
        logic [1:0]  st;
        logic        h;
        logic [15:0] stall;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input string name, input logic r, input logic v,
                                input logic [2:0] rs, input logic rsu,
                                input logic [2:0] rt, input logic rtu,
                                input logic regw, input logic [2:0] rd,
                                input logic halt, input logic br, input logic busy,
                                input logic [4:0] en, input logic [1:0] st,
                                input logic h, input logic [15:0] stall);
        vec_t x;
        x.name = name; x.rst = r; x.valid = v; x.rs = rs; x.rsu = rsu;
        x.rt = rt; x.rtu = rtu; x.regw = regw; x.rd = rd; x.halt = halt;
        x.br = br; x.busy = busy; x.en = en; x.st = st; x.h = h; x.stall = stall;
        return x;
    endfunction

    task automatic step(input vec_t v);
        vec_t e;
        logic [4:0] en_act;
        @(posedge clk);
        #1;
        rst             = v.rst;
        bus.id_valid    = v.valid;
        bus.id_rs       = v.rs;
        bus.id_rs_used  = v.rsu;
        bus.id_rt       = v.rt;
        bus.id_rt_used  = v.rtu;
        bus.id_regwrt   = v.regw;
        bus.id_rd       = v.rd;
        bus.id_halt     = v.halt;
        bus.ex_br_taken = v.br;
        bus.mem_busy    = v.busy;
        exp_q.push_back(v);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, no expected record", v.name);
        end else begin
            e = exp_q.pop_front();
            en_act = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.ifid_flush, bus.idex_bubble};
            if (en_act !== e.en) begin
                errors++;
                $display("FAIL %s/en: got %b want %b", e.name, en_act, e.en);
            end
            checks++;
            if (bus.state !== e.st) begin
                errors++;
                $display("FAIL %s/state: got %0d want %0d", e.name, bus.state, e.st);
            end
            checks++;
            if (bus.halted !== e.h) begin
                errors++;
                $display("FAIL %s/halted: got %b want %b", e.name, bus.halted, e.h);
            end
            checks++;
            if (bus.stall_cycles !== e.stall) begin
                errors++;
                $display("FAIL %s/stall_cycles: got %0d want %0d", e.name, bus.stall_cycles, e.stall);
            end
        end
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_rs = 3'd0; bus.id_rs_used = 1'b0;
        bus.id_rt = 3'd0; bus.id_rt_used = 1'b0; bus.id_regwrt = 1'b0;
        bus.id_rd = 3'd0; bus.id_halt = 1'b0; bus.ex_br_taken = 1'b0;
        bus.mem_busy = 1'b0;
        repeat (2) @(posedge clk);

        //                 name          rst  v     rs    rsu   rt    rtu   rw    rd    hlt   br    busy  en        st    h     stall
        tbl.push_back(mk("reset",        1'b1,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11111,2'd0,1'b0,16'd0));
        tbl.push_back(mk("idle",         1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd0));
        tbl.push_back(mk("wr_r3",        1'b0,1'b1,3'd1,1'b1,3'd0,1'b0,1'b1,3'd3,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd0));
        tbl.push_back(mk("use_r3_ex",    1'b0,1'b1,3'd3,1'b1,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b00101,2'd0,1'b0,16'd0));
        tbl.push_back(mk("use_r3_mem",   1'b0,1'b1,3'd3,1'b1,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b00101,2'd0,1'b0,16'd1));
        tbl.push_back(mk("use_r3_go",    1'b0,1'b1,3'd3,1'b1,3'd0,1'b0,1'b1,3'd5,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd2));
        tbl.push_back(mk("rt_unused",    1'b0,1'b1,3'd0,1'b1,3'd5,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd2));
        tbl.push_back(mk("rt_mem_raw",   1'b0,1'b1,3'd0,1'b0,3'd5,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,5'b00101,2'd0,1'b0,16'd2));
        tbl.push_back(mk("wr_r0",        1'b0,1'b1,3'd1,1'b0,3'd2,1'b0,1'b1,3'd0,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd3));
        tbl.push_back(mk("br_vs_raw",    1'b0,1'b1,3'd0,1'b1,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0,5'b11111,2'd0,1'b0,16'd3));
        tbl.push_back(mk("raw_r0_mem",   1'b0,1'b1,3'd0,1'b1,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b00101,2'd0,1'b0,16'd3));
        tbl.push_back(mk("wr_r6",        1'b0,1'b1,3'd1,1'b0,3'd2,1'b0,1'b1,3'd6,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd4));
        tbl.push_back(mk("raw_r6",       1'b0,1'b1,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,5'b00101,2'd0,1'b0,16'd4));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk("freeze",   1'b0,1'b1,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b0,1'b0,1'b1,5'b00000,2'd0,1'b0,16'(5 + i)));
        end
        tbl.push_back(mk("raw_r6_after", 1'b0,1'b1,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,5'b00101,2'd0,1'b0,16'd9));
        tbl.push_back(mk("r6_issue",     1'b0,1'b1,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd10));
        tbl.push_back(mk("busy_over_br", 1'b0,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b1,5'b00000,2'd0,1'b0,16'd10));

        foreach (tbl[i]) step(tbl[i]);

        // Halt squash, halt issue, drain extended by one frozen cycle, halted.
        step(mk("halt_squash",  1'b0,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b1,1'b1,1'b0,5'b11111,2'd0,1'b0,16'd11));
        step(mk("halt_issue",   1'b0,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b1,1'b0,1'b0,5'b01110,2'd0,1'b0,16'd11));
        step(mk("drain0",       1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b01111,2'd1,1'b0,16'd11));
        step(mk("drain_busy",   1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b1,5'b00000,2'd1,1'b0,16'd11));
        step(mk("drain1",       1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b01111,2'd1,1'b0,16'd11));
        step(mk("drain2",       1'b0,1'b1,3'd3,1'b1,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0,5'b01111,2'd1,1'b0,16'd11));
        step(mk("halted",       1'b0,1'b1,3'd0,1'b0,3'd0,1'b0,1'b1,3'd2,1'b0,1'b0,1'b0,5'b00000,2'd2,1'b1,16'd11));
        step(mk("halted_br",    1'b0,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0,5'b00000,2'd2,1'b1,16'd11));
        step(mk("rst_halted",   1'b1,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11111,2'd2,1'b1,16'd11));
        step(mk("post_rst",     1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd0));

        // Reset in the middle of a drain.
        step(mk("halt_issue2",  1'b0,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b1,1'b0,1'b0,5'b01110,2'd0,1'b0,16'd0));
        step(mk("drain_a",      1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b01111,2'd1,1'b0,16'd0));
        step(mk("rst_in_drain", 1'b1,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11111,2'd1,1'b0,16'd0));
        step(mk("after_rst",    1'b0,1'b1,3'd3,1'b1,3'd4,1'b1,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11100,2'd0,1'b0,16'd0));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d queued records want 0", exp_q.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
